// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: Count/Compare timer, Status, Cause, EPC, mfc0 reads.
// Writes land one cycle after the strobe edge; no handshake, strobes accepted every cycle.
module cp0_regfile #(
  parameter int CLK_DIV = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  hwint,
  input  logic        writestatus,
  input  logic        writecause,
  input  logic        writeepc,
  input  logic        exl,
  input  logic        ie,
  input  logic        db,
  input  logic [4:0]  exccode,
  input  logic [1:0]  selepc,
  input  logic [31:0] epcin0,
  input  logic [31:0] epcin1,
  input  logic [31:0] epcin2,
  input  logic [31:0] epcin3,
  input  logic        mfc0,
  input  logic        mtc0,
  input  logic [4:0]  rd,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        intr,
  output logic [7:0]  imip,
  output logic [31:0] epc,
  output logic [31:0] status,
  output logic [31:0] cause
);

  localparam logic [4:0]  RD_COUNT   = 5'd9;
  localparam logic [4:0]  RD_COMPARE = 5'd11;
  localparam logic [4:0]  RD_STATUS  = 5'd12;
  localparam logic [4:0]  RD_CAUSE   = 5'd13;
  localparam logic [4:0]  RD_EPC     = 5'd14;
  localparam logic [31:0] PRESC_MAX  = 32'((64'd1 << CLK_DIV) - 64'd1);

  logic [31:0] count_q, compare_q, epc_q, presc_q;
  logic [7:0]  im_q, ip_q;
  logic        exl_q, ie_q, bd_q;
  logic [4:0]  exc_q;

  logic        tick, timer_hit;
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic [31:0] count_inc, epc_sel;

  assign tick       = (presc_q == PRESC_MAX);
  assign count_inc  = count_q + 32'd1;
  assign wr_count   = mtc0 && (rd == RD_COUNT);
  assign wr_compare = mtc0 && (rd == RD_COMPARE);
  assign wr_status  = mtc0 && (rd == RD_STATUS);
  assign wr_cause   = mtc0 && (rd == RD_CAUSE);
  assign wr_epc     = mtc0 && (rd == RD_EPC);

  // Match is only taken on a real increment; an mtc0 to Count suppresses it.
  assign timer_hit  = tick && !wr_count && (count_inc == compare_q) && (compare_q != 32'd0);

  always_comb begin
    epc_sel = epcin0;
    case (selepc)
      2'd1:    epc_sel = epcin1;
      2'd2:    epc_sel = epcin2;
      2'd3:    epc_sel = epcin3;
      default: epc_sel = epcin0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
      epc_q     <= '0;
      im_q      <= '0;
      ip_q      <= '0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      bd_q      <= 1'b0;
      exc_q     <= '0;
    end else begin
      presc_q <= tick ? 32'd0 : presc_q + 32'd1;

      if (wr_count)  count_q <= wdata;
      else if (tick) count_q <= count_inc;

      if (wr_compare) compare_q <= wdata;

      if (wr_status) im_q <= wdata[15:8];
      // Interrupt entry clears IE, exception entry keeps it, eret sets it.
      if (writestatus) begin
        exl_q <= exl;
        ie_q  <= ie & (ie_q | ~exl);
      end else if (wr_status) begin
        exl_q <= wdata[1];
        ie_q  <= wdata[0];
      end

      if (writecause) begin
        bd_q  <= db;
        exc_q <= exccode;
      end

      ip_q[6:2] <= hwint;
      if (wr_cause)        ip_q[1:0] <= wdata[9:8];
      if (wr_compare)      ip_q[7]   <= 1'b0;
      else if (timer_hit)  ip_q[7]   <= 1'b1;

      if (writeepc)    epc_q <= epc_sel;
      else if (wr_epc) epc_q <= wdata;
    end
  end

  assign status = {16'd0, im_q, 6'd0, exl_q, ie_q};
  assign cause  = {bd_q, 15'd0, ip_q, 1'b0, exc_q, 2'd0};
  assign epc    = epc_q;
  assign intr   = ie_q & ~exl_q;
  assign imip   = im_q & ip_q;

  always_comb begin
    rdata = 32'd0;
    if (mfc0) begin
      case (rd)
        RD_COUNT:   rdata = count_q;
        RD_COMPARE: rdata = compare_q;
        RD_STATUS:  rdata = status;
        RD_CAUSE:   rdata = cause;
        RD_EPC:     rdata = epc_q;
        default:    rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Randomized scoreboard bench for cp0_regfile against an architectural CP0 model.
module tb_cp0_regfile;

  localparam int DIV = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  hwint;
  logic        writestatus, writecause, writeepc, exl, ie, db;
  logic [4:0]  exccode;
  logic [1:0]  selepc;
  logic [31:0] epcin0, epcin1, epcin2, epcin3;
  logic        mfc0, mtc0;
  logic [4:0]  rd;
  logic [31:0] wdata;
  logic [31:0] rdata, epc, status, cause;
  logic        intr;
  logic [7:0]  imip;

  cp0_regfile #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .hwint(hwint),
    .writestatus(writestatus), .writecause(writecause), .writeepc(writeepc),
    .exl(exl), .ie(ie), .db(db), .exccode(exccode), .selepc(selepc),
    .epcin0(epcin0), .epcin1(epcin1), .epcin2(epcin2), .epcin3(epcin3),
    .mfc0(mfc0), .mtc0(mtc0), .rd(rd), .wdata(wdata),
    .rdata(rdata), .intr(intr), .imip(imip), .epc(epc),
    .status(status), .cause(cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] status, cause, epc, rdata;
    logic        intr;
    logic [7:0]  imip;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Architectural state of CP0, kept as plain named registers.
  bit        mv = 0;
  int        m_presc;
  bit [31:0] m_count, m_compare, m_epc;
  bit [7:0]  m_im, m_ip;
  bit        m_exl, m_ie, m_bd;
  bit [4:0]  m_exc;

  function automatic bit [31:0] m_status();
    return {16'd0, m_im, 6'd0, m_exl, m_ie};
  endfunction

  function automatic bit [31:0] m_cause();
    return {m_bd, 15'd0, m_ip, 1'b0, m_exc, 2'd0};
  endfunction

  function automatic bit [31:0] m_read(input bit [4:0] r);
    case (r)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status();
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic model_edge();
    bit        tick, hit;
    bit [31:0] epcs [4];
    if (rst) begin
      m_presc = 0; m_count = 0; m_compare = 0; m_epc = 0;
      m_im = 0; m_ip = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_exc = 0;
      mv = 1;
      return;
    end
    epcs[0] = epcin0; epcs[1] = epcin1; epcs[2] = epcin2; epcs[3] = epcin3;
    tick = (m_presc == (1 << DIV) - 1);
    m_presc = tick ? 0 : m_presc + 1;
    hit = tick && !(mtc0 && rd == 9) && (m_count + 32'd1 == m_compare) && (m_compare != 0);
    if (mtc0 && rd == 9) m_count = wdata;
    else if (tick)       m_count = m_count + 32'd1;
    if (mtc0 && rd == 12) m_im = wdata[15:8];
    if (writestatus) begin
      m_ie  = ie && (m_ie || !exl);
      m_exl = exl;
    end else if (mtc0 && rd == 12) begin
      m_exl = wdata[1];
      m_ie  = wdata[0];
    end
    if (writecause) begin m_bd = db; m_exc = exccode; end
    m_ip[6:2] = hwint;
    if (mtc0 && rd == 13) m_ip[1:0] = wdata[9:8];
    if (mtc0 && rd == 11) begin m_ip[7] = 0; m_compare = wdata; end
    else if (hit)          m_ip[7] = 1;
    if (writeepc)              m_epc = epcs[selepc];
    else if (mtc0 && rd == 14) m_epc = wdata;
  endtask

  // Called at posedge+1 once inputs for the coming edge are set.
  task automatic step();
    exp_t e;
    if (mv) begin
      e.status = m_status();
      e.cause  = m_cause();
      e.epc    = m_epc;
      e.intr   = m_ie && !m_exl;
      e.imip   = m_im & m_ip;
      e.rdata  = mfc0 ? m_read(rd) : 32'd0;
      exp_q.push_back(e);
    end
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rst = 0; writestatus = 0; writecause = 0; writeepc = 0;
    exl = 0; ie = 0; db = 0; exccode = 0; selepc = 0;
    mfc0 = 0; mtc0 = 0; rd = 0; wdata = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("status", status, e.status);
        cmp("cause",  cause,  e.cause);
        cmp("epc",    epc,    e.epc);
        cmp("rdata",  rdata,  e.rdata);
        cmp("intr",   {31'd0, intr}, {31'd0, e.intr});
        cmp("imip",   {24'd0, imip}, {24'd0, e.imip});
      end
    end
  end

  initial begin : driver
    int hit_at;
    bit [4:0] rd_tab [5];
    rd_tab[0] = 9; rd_tab[1] = 11; rd_tab[2] = 12; rd_tab[3] = 13; rd_tab[4] = 14;
    quiet();
    hwint = 0;
    epcin0 = 32'h1000_0000; epcin1 = 32'h2000_0004; epcin2 = 32'h0040_0010; epcin3 = 32'h3000_000c;
    rst = 1;
    step();
    step();
    rst = 0;
    repeat (3) step();

    mfc0 = 1; rd = 9; #1;
    cmp("count_after_3", rdata, 32'd3);
    cmp("reset_status", status, 32'd0);
    cmp("reset_cause", cause, 32'd0);
    cmp("reset_epc", epc, 32'd0);
    step();

    quiet(); hwint = 5'b00001; mtc0 = 1; rd = 12; wdata = 32'h0000_FF01;
    step();
    quiet();
    cmp("intr_enabled", {31'd0, intr}, 32'd1);
    cmp("imip_hw0", {24'd0, imip}, 32'h04);

    writestatus = 1; writecause = 1; writeepc = 1;
    exl = 1; ie = 1; exccode = 5'd12; db = 1; selepc = 2;
    step();
    quiet();
    cmp("exc_status", status, 32'h0000_FF03);
    cmp("exc_bd", {31'd0, cause[31]}, 32'd1);
    cmp("exc_code", {27'd0, cause[6:2]}, 32'd12);
    cmp("exc_epc", epc, 32'h0040_0010);
    cmp("exc_intr", {31'd0, intr}, 32'd0);
    writestatus = 1; exl = 0; ie = 1;
    step();
    quiet();
    cmp("eret_status", status, 32'h0000_FF01);
    cmp("eret_intr", {31'd0, intr}, 32'd1);

    mtc0 = 1; rd = 11; wdata = 32'd5;
    step();
    mtc0 = 1; rd = 9; wdata = 32'd0;
    step();
    quiet();
    cmp("timer_idle", {31'd0, cause[15]}, 32'd0);
    hit_at = 0;
    for (int i = 1; i <= 10 && hit_at == 0; i++) begin
      step();
      if (cause[15]) hit_at = i;
    end
    cmp("timer_cycles", hit_at, 32'd5);
    mtc0 = 1; rd = 11; wdata = 32'd100;
    step();
    quiet();
    cmp("timer_clear", {31'd0, cause[15]}, 32'd0);

    writestatus = 1; exl = 1; ie = 1; mtc0 = 1; rd = 12; wdata = 32'd0;
    step();
    quiet();
    cmp("prio_status", status, 32'h0000_0003);

    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 299) == 0);
      hwint       = 5'($urandom);
      writestatus = ($urandom_range(0, 5) == 0);
      writecause  = ($urandom_range(0, 5) == 0);
      writeepc    = ($urandom_range(0, 5) == 0);
      exl = 1'($urandom); ie = 1'($urandom); db = 1'($urandom);
      exccode = 5'($urandom); selepc = 2'($urandom);
      epcin0 = $urandom; epcin1 = $urandom; epcin2 = $urandom; epcin3 = $urandom;
      mfc0 = 1'($urandom);
      mtc0 = ($urandom_range(0, 3) == 0);
      rd   = ($urandom_range(0, 3) != 0) ? rd_tab[$urandom_range(0, 4)] : 5'($urandom);
      wdata = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40));
      step();
    end

    quiet();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
